// File: rtl/logic_stream_unit.sv
// Pipelined W-bit logic unit: selectable bitwise gate per beat, or a multi-beat
// NOR reduction. Results leave through a 2-entry {y, cnt} output queue.
module logic_stream_unit #(
    parameter int W    = 8,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_val,
    output logic            in_rdy,
    input  logic [2:0]      in_op,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic            in_last,
    output logic            out_val,
    input  logic            out_rdy,
    output logic [W-1:0]    out_y,
    output logic [CNTW-1:0] out_cnt
);

    typedef enum logic {IDLE, ACC} state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [2:0]      OP_NOT  = 3'd6;
    localparam logic [2:0]      OP_RED  = 3'd7;

    state_t          state_reg, state_next;
    logic [W-1:0]    acc_reg, acc_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;

    logic [W-1:0]    y_mem [2];
    logic [CNTW-1:0] cnt_mem [2];
    logic            wr_ptr_reg, rd_ptr_reg;
    logic [1:0]      occ_reg;

    logic            in_fire, out_fire;
    logic            enq;
    logic [W-1:0]    enq_y;
    logic [CNTW-1:0] enq_cnt;
    logic [W-1:0]    gate_y;
    logic [W-1:0]    red_sum;
    logic [CNTW-1:0] cnt_inc;

    // Ready depends on registered occupancy only (plus reset), never on out_rdy.
    assign in_rdy   = !reset && (occ_reg != 2'd2);
    assign out_val  = (occ_reg != 2'd0);
    assign out_y    = y_mem[rd_ptr_reg];
    assign out_cnt  = cnt_mem[rd_ptr_reg];
    assign in_fire  = in_val && in_rdy;
    assign out_fire = out_val && out_rdy;

    assign red_sum = acc_reg | in_a;
    assign cnt_inc = cnt_reg + CNTW'(1);

    always_comb begin
        gate_y = '0;
        case (in_op)
            3'd0:    gate_y = ~(in_a | in_b);
            3'd1:    gate_y = ~(in_a & in_b);
            3'd2:    gate_y = in_a & in_b;
            3'd3:    gate_y = in_a | in_b;
            3'd4:    gate_y = in_a ^ in_b;
            3'd5:    gate_y = ~(in_a ^ in_b);
            default: gate_y = ~in_a;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        enq        = 1'b0;
        enq_y      = '0;
        enq_cnt    = '0;
        if (in_fire) begin
            case (state_reg)
                IDLE: begin
                    if (in_op != OP_RED) begin
                        enq     = 1'b1;
                        enq_y   = gate_y;
                        enq_cnt = (in_op == OP_NOT) ? CNTW'(1) : CNTW'(2);
                    end else if (in_last || (CNTW == 1)) begin
                        enq     = 1'b1;
                        enq_y   = ~in_a;
                        enq_cnt = CNTW'(1);
                    end else begin
                        acc_next   = in_a;
                        cnt_next   = CNTW'(1);
                        state_next = ACC;
                    end
                end
                default: begin
                    // A beat that would take the counter to its ceiling closes the reduction.
                    if (in_last || (cnt_inc == CNT_MAX)) begin
                        enq        = 1'b1;
                        enq_y      = ~red_sum;
                        enq_cnt    = cnt_inc;
                        acc_next   = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        acc_next = red_sum;
                        cnt_next = cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                y_mem[i]   <= '0;
                cnt_mem[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            if (enq) begin
                y_mem[wr_ptr_reg]   <= enq_y;
                cnt_mem[wr_ptr_reg] <= enq_cnt;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (out_fire) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({enq, out_fire})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_stream_unit.sv
// Bench for logic_stream_unit: two instances (CNTW=8 and CNTW=2) share one
// input stream; per-instance scoreboards check every dequeued result.
module tb_logic_stream_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_val;
    logic [2:0] in_op;
    logic [7:0] in_a, in_b;
    logic       in_last;
    logic       out_rdy;

    logic       in_rdy1, out_val1;
    logic [7:0] out_y1, out_cnt1;
    logic       in_rdy2, out_val2;
    logic [7:0] out_y2;
    logic [1:0] out_cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] y;
        logic [7:0] cnt;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    logic_stream_unit #(.W(8), .CNTW(8)) dut1 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy1),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_val(out_val1), .out_rdy(out_rdy), .out_y(out_y1), .out_cnt(out_cnt1)
    );

    logic_stream_unit #(.W(8), .CNTW(2)) dut2 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy2),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_val(out_val2), .out_rdy(out_rdy), .out_y(out_y2), .out_cnt(out_cnt2)
    );

    // Monitors: sample mid-cycle; a transfer happens at the following posedge.
    always @(negedge clk) begin
        if (!reset && out_val1 && out_rdy) begin
            exp_t e;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected: y=%02h cnt=%0d with no expected entry", out_y1, out_cnt1);
            end else begin
                e = q1.pop_front();
                if (out_y1 !== e.y || out_cnt1 !== e.cnt) begin
                    errors++;
                    $display("FAIL dut1_result: got y=%02h cnt=%0d expected y=%02h cnt=%0d",
                             out_y1, out_cnt1, e.y, e.cnt);
                end else begin
                    $display("dut1 out y=%02h cnt=%0d ok", out_y1, out_cnt1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_val2 && out_rdy) begin
            exp_t e;
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL dut2_unexpected: y=%02h cnt=%0d with no expected entry", out_y2, out_cnt2);
            end else begin
                e = q2.pop_front();
                if (out_y2 !== e.y || {6'd0, out_cnt2} !== e.cnt) begin
                    errors++;
                    $display("FAIL dut2_result: got y=%02h cnt=%0d expected y=%02h cnt=%0d",
                             out_y2, out_cnt2, e.y, e.cnt);
                end else begin
                    $display("dut2 out y=%02h cnt=%0d ok", out_y2, out_cnt2);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, expv);
        end
    endtask

    task automatic push(input logic [7:0] y, input logic [7:0] c1, input logic [7:0] c2);
        exp_t e1, e2;
        e1.y = y; e1.cnt = c1;
        e2.y = y; e2.cnt = c2;
        q1.push_back(e1);
        q2.push_back(e2);
    endtask

    task automatic push1(input logic [7:0] y, input logic [7:0] c);
        exp_t e;
        e.y = y; e.cnt = c;
        q1.push_back(e);
    endtask

    task automatic push2(input logic [7:0] y, input logic [7:0] c);
        exp_t e;
        e.y = y; e.cnt = c;
        q2.push_back(e);
    endtask

    // Called at posedge+2; returns at posedge+2 just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic last);
        int  n = 0;
        bit  done = 0;
        in_val  = 1'b1;
        in_op   = op;
        in_a    = a;
        in_b    = b;
        in_last = last;
        while (!done) begin
            @(negedge clk);
            if (in_rdy1 && in_rdy2) begin
                done = 1;
            end else if (++n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: beat op=%0d a=%02h never accepted", op, a);
                done = 1;
            end
            @(posedge clk); #2;
        end
        in_val = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    logic [7:0] t1_a [4] = '{8'h00, 8'h0F, 8'hFF, 8'hAA};
    logic [7:0] t1_b [4] = '{8'h00, 8'hF0, 8'h00, 8'hAA};
    logic [7:0] t1_y [4] = '{8'hFF, 8'h00, 8'h00, 8'h55};
    logic [7:0] t2_y [6] = '{8'h77, 8'h88, 8'hEE, 8'h66, 8'h99, 8'h33};

    initial begin
        reset = 1'b1; in_val = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_last = 1'b0; out_rdy = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy", {7'd0, in_rdy1}, 8'd0);
        chk("rst_out_val", {7'd0, out_val1}, 8'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_rdy", {7'd0, in_rdy1}, 8'd1);
        chk("post_rst_in_rdy2", {7'd0, in_rdy2}, 8'd1);
        chk("post_rst_out_val", {7'd0, out_val1}, 8'd0);
        chk("post_rst_out_y", out_y1, 8'd0);
        chk("post_rst_out_cnt", out_cnt1, 8'd0);
        @(posedge clk); #2;

        // NOR vectors with one-cycle latency
        for (int i = 0; i < 4; i++) begin
            $display("beat nor a=%02h b=%02h", t1_a[i], t1_b[i]);
            push(t1_y[i], 8'd2, 8'd2);
            send(3'd0, t1_a[i], t1_b[i], 1'b0);
            @(negedge clk);
            chk("nor_latency", {7'd0, out_val1}, 8'd1);
            @(posedge clk); #2;
        end

        // Operation sweep
        for (int op = 1; op <= 6; op++) begin
            $display("beat op=%0d a=cc b=aa", op);
            push(t2_y[op-1], (op == 6) ? 8'd1 : 8'd2, (op == 6) ? 8'd1 : 8'd2);
            send(3'(op), 8'hCC, 8'hAA, 1'b0);
        end
        idle(3);

        // Reduction, in_op ignored on the middle beat
        $display("reduce 01,10,80");
        send(3'd7, 8'h01, 8'h55, 1'b0);
        @(negedge clk); chk("red_no_out_1", {7'd0, out_val1}, 8'd0);
        @(posedge clk); #2;
        send(3'd3, 8'h10, 8'hFF, 1'b0);
        @(negedge clk); chk("red_no_out_2", {7'd0, out_val1}, 8'd0);
        @(posedge clk); #2;
        push(8'h6E, 8'd3, 8'd3);
        send(3'd7, 8'h80, 8'h00, 1'b1);
        idle(3);

        // Backpressure
        $display("backpressure");
        out_rdy = 1'b0;
        push(8'hFC, 8'd2, 8'd2);
        send(3'd0, 8'h01, 8'h02, 1'b0);
        push(8'hCF, 8'd2, 8'd2);
        send(3'd0, 8'h10, 8'h20, 1'b0);
        push(8'hF0, 8'd2, 8'd2);
        in_val = 1'b1; in_op = 3'd0; in_a = 8'h00; in_b = 8'h0F; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_full_in_rdy", {7'd0, in_rdy1}, 8'd0);
            @(posedge clk); #2;
        end
        out_rdy = 1'b1;
        @(negedge clk);
        chk("bp_full_out_rdy_in_rdy", {7'd0, in_rdy1}, 8'd0);
        @(posedge clk); #2;
        @(negedge clk);
        chk("bp_drain_in_rdy", {7'd0, in_rdy1}, 8'd1);
        @(posedge clk); #2;
        in_val = 1'b0;
        idle(4);

        // Reset mid-reduction discards the partial result
        $display("reset mid-reduction");
        send(3'd7, 8'h01, 8'h00, 1'b0);
        send(3'd7, 8'h02, 8'h00, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_val", {7'd0, out_val1}, 8'd0);
        chk("midrst_in_rdy", {7'd0, in_rdy1}, 8'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("after_midrst_out_val", {7'd0, out_val1}, 8'd0);
        @(posedge clk); #2;
        push(8'hFF, 8'd2, 8'd2);
        send(3'd0, 8'h00, 8'h00, 1'b0);
        idle(3);

        // Counter saturation: dut2 (CNTW=2) forces the 3rd beat final
        $display("saturation");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) push2(8'hFF, 8'd3);
            send(3'd7, 8'h00, 8'h00, 1'b0);
            if (i == 2) begin
                @(negedge clk);
                chk("sat_dut2_out_val", {7'd0, out_val2}, 8'd1);
                chk("sat_dut1_out_val", {7'd0, out_val1}, 8'd0);
                @(posedge clk); #2;
            end
        end
        push1(8'hFF, 8'd6);
        push2(8'hFF, 8'd3);
        send(3'd7, 8'h00, 8'h00, 1'b1);
        idle(5);

        chk("q1_drained", 8'(q1.size()), 8'd0);
        chk("q2_drained", 8'(q2.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_stream_unit.md
Name: logic_stream_unit

Overview:
- Parametrised, pipelined successor to the single-bit 2-input NOR gate.
- Applies a selectable bitwise logic operation to W-bit operand pairs arriving on a val/rdy input stream.
- Supports a multi-beat NOR reduction mode, which NORs an arbitrary number of W-bit operands across consecutive beats.
- Results leave on a val/rdy output stream through a 2-entry output queue; the block is a drop-in datapath stage for the gate-level teaching designs.

Parameters:
- W, 8, operand/result width in bits (W >= 1).
- CNTW, 8, width of the reduction beat counter; maximum reduction length is 2^CNTW - 1 beats.

Ports:
- clk      input   1     clock; all state updates on posedge.
- reset    input   1     synchronous, active-high reset.
- in_val   input   1     input beat valid.
- in_rdy   output  1     block can accept a beat.
- in_op    input   3     operation select (see Behaviour).
- in_a     input   W     operand A.
- in_b     input   W     operand B (ignored in reduce mode).
- in_last  input   1     final beat of a reduction (reduce mode only).
- out_val  output  1     result valid.
- out_rdy  input   1     consumer accepts result.
- out_y    output  W     result.
- out_cnt  output  CNTW  operand count that produced out_y.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Transfers:
  - Input transfer occurs when in_val && in_rdy at posedge.
  - Output transfer occurs when out_val && out_rdy at posedge.
- in_op encoding and out_cnt:
  - 0 NOR ~(a|b), 1 NAND ~(a&b), 2 AND, 3 OR, 4 XOR, 5 XNOR: out_cnt = 2.
  - 6 NOT ~a: out_cnt = 1.
  - 7 REDUCE-NOR.
- Queue:
  - 2-entry FIFO of {y, cnt}.
  - in_rdy = (entries < 2), driven only from registered occupancy; no combinational path from out_rdy to in_rdy.
  - out_val = (entries > 0); out_y/out_cnt show the head entry.
  - When the queue is full, in_rdy = 0 even if out_rdy = 1 in the same cycle.
  - Simultaneous enqueue and dequeue with 1 entry: occupancy stays 1, FIFO order kept.
- Latency: a result enqueued at posedge N is visible on out_val/out_y after that edge (1-cycle latency when the queue is empty).
- State machine: IDLE, ACC.
  - IDLE, accepted beat, op 0-6: enqueue result; stay IDLE.
  - IDLE, accepted beat, op 7, in_last = 1: enqueue ~a, cnt = 1; stay IDLE.
  - IDLE, accepted beat, op 7, in_last = 0: acc <= a, cnt <= 1; go to ACC; nothing enqueued.
  - ACC, accepted beat: in_op is ignored and the beat is always treated as reduction.
    - acc <= acc | a; cnt <= cnt + 1.
    - If in_last: enqueue ~(acc|a) with cnt + 1, then go to IDLE.
  - ACC, counter reaching 2^CNTW - 1: the beat is forced final (treated as in_last = 1) to avoid wrap; out_cnt saturates at 2^CNTW - 1.
  - In ACC, in_rdy follows the same queue rule. Non-final beats do not need queue space but are still gated by in_rdy.
- in_b is ignored for op 6 and op 7.
- Reset:
  - Clears the queue: out_val = 0, out_y = 0, out_cnt = 0.
  - State = IDLE; acc = 0; cnt = 0.
  - in_rdy = 0 while reset is high, 1 in the first cycle after reset deasserts.
  - Reset mid-reduction discards the partial result; nothing is emitted.
- All arithmetic is unsigned. Results are exactly W bits with no extension.

Test Plan:
- W=8. Apply (op0, a=0x00, b=0x00), (0, 0x0F, 0xF0), (0, 0xFF, 0x00), (0, 0xAA, 0xAA) with out_rdy=1 -> out_y = 0xFF, 0x00, 0x00, 0x55; out_cnt = 2 each; each result 1 cycle after acceptance.
- Op sweep with a=0xCC, b=0xAA, ops 1-6 -> 0x77, 0x88, 0xEE, 0x66, 0x99, 0x33 (NOT gives out_cnt = 1).
- Reduce over beats a = 0x01, 0x10, 0x80 (last on 3rd), with in_op = 3 on the 2nd beat -> in_op ignored; single output 0x6E, out_cnt = 3; no output after beats 1-2.
- Backpressure:
  - out_rdy=0, push 3 beats -> in_rdy drops after 2 accepts, 3rd beat stalls.
  - Raise out_rdy -> results drain in order; 3rd beat accepted only after occupancy < 2.
- Reset mid-reduction: 2 non-last reduce beats, assert reset 1 cycle, then NOR 0x00,0x00 -> only output is 0xFF, cnt 2; out_val = 0 during and right after reset.
- Saturation with CNTW=2: reduce 5 beats of a=0x00 without in_last -> output 0xFF with out_cnt = 3 after the 3rd beat; beats 4-5 start a new reduction.
